// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 UART receiver (LSB first, idle-high line). It collects
// 1-4 consecutive bytes into one 32-bit word and presents the word with a
// single-cycle valid pulse. There is no backpressure.
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   rx           serial input, asynchronous to clk, idle high
//   num_of_data  bytes per word (0 -> 1, >=4 -> 4), latched at the first byte
//   dat          assembled word; byte k in dat[8k+7:8k], unused bytes zero
//   dat_valid    one-cycle pulse when dat is updated
//   frame_err    one-cycle pulse on a bad stop bit
//   busy         frame in progress or word partially assembled
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx,
    input  logic [2:0]  num_of_data,
    output logic [31:0] dat,
    output logic        dat_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK
    } state_e;

    state_e           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [1:0]       last_idx_q, last_idx_d;   // latched byte count minus one
    logic [7:0]       shift_q, shift_d;
    logic [31:0]      word_q, word_d;
    logic [31:0]      dat_q, dat_d;
    logic             dat_valid_q, dat_valid_d;
    logic             frame_err_q, frame_err_d;

    logic [1:0]       clamp_idx;
    logic [31:0]      word_ins;   // word buffer with the current byte inserted
    logic [31:0]      word_mask;  // keeps only the bytes belonging to this word

    // Two-flop synchronizer; resets to the idle level so reset never looks
    // like a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        case (num_of_data)
            3'd0, 3'd1: clamp_idx = 2'd0;
            3'd2:       clamp_idx = 2'd1;
            3'd3:       clamp_idx = 2'd2;
            default:    clamp_idx = 2'd3;
        endcase
    end

    always_comb begin
        word_ins  = word_q;
        word_mask = '0;
        for (int k = 0; k < 4; k++) begin
            if (byte_idx_q == 2'(k)) word_ins[8*k +: 8] = shift_q;
            if (2'(k) <= last_idx_q) word_mask[8*k +: 8] = 8'hFF;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        byte_idx_d  = byte_idx_q;
        last_idx_d  = last_idx_q;
        shift_d     = shift_q;
        word_d      = word_q;
        dat_d       = dat_q;
        dat_valid_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    if (!rx_s_q) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                        if (byte_idx_q == 2'd0) last_idx_d = clamp_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                        if (byte_idx_q == last_idx_q) begin
                            dat_d       = word_ins & word_mask;
                            dat_valid_d = 1'b1;
                            byte_idx_d  = 2'd0;
                            word_d      = '0;
                        end else begin
                            word_d     = word_ins;
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end else begin
                        state_d     = BREAK;
                        frame_err_d = 1'b1;
                        byte_idx_d  = 2'd0;
                        word_d      = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                // Hold off until the line is released, so a stuck-low line is
                // not decoded as a stream of start bits.
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            byte_idx_q  <= '0;
            last_idx_q  <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            dat_q       <= '0;
            dat_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            byte_idx_q  <= byte_idx_d;
            last_idx_q  <= last_idx_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            dat_q       <= dat_d;
            dat_valid_q <= dat_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign dat       = dat_q;
    assign dat_valid = dat_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE) || (byte_idx_q != 2'd0);

endmodule
